ifu_fetch_ctrl: RTL

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_fetch_ctrl_pkg.sv | 14 +
 rtl/ifu_inst_buf.sv | 48 ++++
 rtl/ifu_fetch_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state encoding
// and the default reset fetch address.
package ifu_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetchState_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_inst_buf.sv
// Single-entry output buffer between the fetch FSM and decode. A flush drops
// the held entry; the payload registers keep their last value.
module ifu_inst_buf #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_flush,
    input  logic                i_ready,
    input  logic [DATA_LEN-1:0] i_data,
    input  logic [DATA_LEN-1:0] i_pc,
    input  logic                i_err,
    output logic                o_valid,
    output logic [DATA_LEN-1:0] o_data,
    output logic [DATA_LEN-1:0] o_pc,
    output logic                o_err
);

    logic                r_valid;
    logic [DATA_LEN-1:0] r_data;
    logic [DATA_LEN-1:0] r_pc;
    logic                r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
            r_err   <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
            r_err   <= i_err;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
    assign o_err   = r_err;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory read, single-entry
// output buffer, redirects from execute. FETCH_ERR_HALT_EN enables halt-on-fault.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [DATA_LEN-1:0] req_addr,
    input  logic                rsp_valid,
    input  logic [DATA_LEN-1:0] rsp_data,
    input  logic                rsp_err,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst_fetch,
    output logic [DATA_LEN-1:0] pc_out,
    input  logic                Jump_flag,
    input  logic [DATA_LEN-1:0] Jump_PC,
    output logic                inst_err
);

`ifdef FETCH_ERR_HALT_EN
    localparam logic ERR_HALT = 1'b1;
`else
    localparam logic ERR_HALT = 1'b0;
`endif

    localparam logic [DATA_LEN-1:0] PC_STEP = DATA_LEN'(4);

    fetchState_t         r_state;
    logic [DATA_LEN-1:0] r_fetchPc;
    logic [DATA_LEN-1:0] r_reqAddr;
    logic                r_reqValid;
    logic                r_drop;
    logic                r_halt;

    logic                w_reqFire;
    logic                w_instFire;
    logic                w_bufLoad;
    logic                w_bufFlush;
    logic                w_bufValid;
    logic                w_bufErr;
    logic                w_rspErr;
    logic [DATA_LEN-1:0] w_bufData;
    logic [DATA_LEN-1:0] w_bufPc;
    logic [DATA_LEN-1:0] w_nextPc;

    assign w_reqFire  = r_reqValid && req_ready;
    assign w_instFire = w_bufValid && inst_ready;
    assign w_nextPc   = r_fetchPc + PC_STEP;
    assign w_rspErr   = rsp_err & ERR_HALT;
    assign w_bufLoad  = (r_state == WAIT) && rsp_valid && !r_drop && !Jump_flag;
    assign w_bufFlush = (r_state == HOLD) && Jump_flag;

    // r_drop marks a response still owed for an abandoned request; while it is
    // set in REQ the new request is held back so only one read is outstanding.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_fetchPc  <= RESET_PC;
            r_reqAddr  <= RESET_PC;
            r_reqValid <= 1'b0;
            r_drop     <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Jump_flag) begin
                        r_fetchPc  <= Jump_PC;
                        r_reqAddr  <= Jump_PC;
                        r_reqValid <= 1'b1;
                        r_halt     <= 1'b0;
                        r_state    <= REQ;
                    end else if (!r_halt) begin
                        r_reqAddr  <= r_fetchPc;
                        r_reqValid <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (r_drop) begin
                        if (Jump_flag) begin
                            r_fetchPc <= Jump_PC;
                            r_reqAddr <= Jump_PC;
                        end
                        if (rsp_valid) begin
                            r_drop     <= 1'b0;
                            r_reqValid <= 1'b1;
                        end
                    end else if (w_reqFire) begin
                        r_reqValid <= 1'b0;
                        r_state    <= WAIT;
                        if (Jump_flag) begin
                            r_fetchPc <= Jump_PC;
                            r_drop    <= 1'b1;
                        end
                    end else if (Jump_flag) begin
                        r_fetchPc <= Jump_PC;
                        r_reqAddr <= Jump_PC;
                    end
                end
                WAIT: begin
                    if (Jump_flag) begin
                        r_fetchPc  <= Jump_PC;
                        r_reqAddr  <= Jump_PC;
                        r_drop     <= !rsp_valid;
                        r_reqValid <= rsp_valid;
                        r_state    <= REQ;
                    end else if (rsp_valid) begin
                        if (r_drop) begin
                            r_drop     <= 1'b0;
                            r_reqAddr  <= r_fetchPc;
                            r_reqValid <= 1'b1;
                            r_state    <= REQ;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (Jump_flag) begin
                        r_fetchPc  <= Jump_PC;
                        r_reqAddr  <= Jump_PC;
                        r_reqValid <= 1'b1;
                        r_state    <= REQ;
                    end else if (w_instFire) begin
                        if (ERR_HALT && w_bufErr) begin
                            r_halt  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_fetchPc  <= w_nextPc;
                            r_reqAddr  <= w_nextPc;
                            r_reqValid <= 1'b1;
                            r_state    <= REQ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ifu_inst_buf #(
        .DATA_LEN(DATA_LEN)
    ) u_inst_buf (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_load  (w_bufLoad),
        .i_flush (w_bufFlush),
        .i_ready (inst_ready),
        .i_data  (rsp_data),
        .i_pc    (r_reqAddr),
        .i_err   (w_rspErr),
        .o_valid (w_bufValid),
        .o_data  (w_bufData),
        .o_pc    (w_bufPc),
        .o_err   (w_bufErr)
    );

    assign req_valid  = r_reqValid;
    assign req_addr   = r_reqAddr;
    assign inst_valid = w_bufValid;
    assign inst_fetch = w_bufData;
    assign pc_out     = w_bufPc;
    assign inst_err   = w_bufErr;

endmodule
